fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Drives the byte-address PC into the 16-bit instruction memory (async read, big-endian byte pair)
//  and captures returned words into a small prefetch FIFO.
//  Presents instructions to decode with a valid/ready handshake; accepts branch/jump redirects.
//  Flags misaligned or out-of-range fetches. Sits between instruction memory and decode.
// PARAMETERS
//  MEM_BYTES   512      instruction memory size in bytes; valid fetch PCs 0..MEM_BYTES-2, even only
//  RESET_PC    16'h0000 PC loaded on reset
//  FIFO_DEPTH  2        prefetch entries, power of 2, >=2
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  imem_pc         out  16  byte address to instruction memory (= fetch_pc register)
//  imem_ins        in   16  instruction word returned combinationally for imem_pc
//  redirect_valid  in   1   branch/jump taken; sampled at rising edge
//  redirect_pc     in   16  target byte address
//  ins_valid       out  1   FIFO head valid
//  ins_ready       in   1   decode accepts head
//  ins_data        out  16  head instruction word
//  ins_pc          out  16  head instruction byte address
//  halted          out  1   state HALTED (HALT_DETECT_EN only; else tied 0)
//  fault           out  1   state FAULT
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, state=FETCH; ins_valid=0, halted=0, fault=0,
//   ins_data/ins_pc=0 while empty. RESET_PC odd or >MEM_BYTES-2 -> FAULT on first edge.
//  States: FETCH, HALTED, FAULT.
//  FETCH, per edge, no redirect: if FIFO not full, or full and head popped this cycle
//   (ins_valid&ins_ready): push {imem_ins, fetch_pc}; fetch_pc += 2 (16-bit add).
//   FIFO full and no pop: hold fetch_pc, no push (stall).
//  Pop: ins_valid&ins_ready at edge removes head. Simultaneous push+pop on a full FIFO is legal.
//  Range check before push: fetch_pc[0]==1 or fetch_pc > MEM_BYTES-2 -> no push, state=FAULT,
//   fetch_pc held. Entries already in FIFO still drain normally.
//  Redirect (any state): at edge, handshake in that cycle completes (head consumed), all other
//   entries flushed, fetch_pc=redirect_pc, state=FETCH, fault/halted cleared; no push that edge.
//   First redirected instruction: ins_valid=1 after the 2nd edge (1 bubble cycle).
//  Latency: first ins_valid after the 1st edge following reset release.
//   Sustained throughput: 1 instr/cycle while ins_ready=1.
//  FAULT: no fetch; exit only by redirect or reset. fault=1 for the whole state.
//  Wrap: fetch_pc reaching MEM_BYTES faults; no silent wrap to 0.
//  ins_pc/ins_data change only on pop, push-into-empty or flush.
// CONFIGURATION
//  HALT_DETECT_EN defined: a pushed word 16'hFFFF is the HALT instruction. It is enqueued and
//   fetching stops (state HALTED, fetch_pc = HALT address + 2, held). halted=1 once the FIFO
//   has drained the HALT word. Exit by redirect or reset.
//  HALT_DETECT_EN undefined: 16'hFFFF is an ordinary word, no HALTED state, halted tied 0.
// TESTING
//  T1 reset, mem[0..7]=1111,2222,3333,4444, ins_ready=1 -> ins_data 1111,2222,3333,4444 on
//     consecutive cycles, ins_pc 0,2,4,6.
//  T2 ins_ready=0 for 5 cycles -> FIFO holds 2 entries, imem_pc frozen at 4; ready=1 -> no word
//     lost or duplicated.
//  T3 redirect_pc=0x0020 while head pc=2 is popped -> pc 2 consumed, pc 4 flushed,
//     one bubble, next ins_pc=0x0020.
//  T4 redirect_pc=0x0021 -> fault=1 next cycle, ins_valid=0, no fetch;
//     redirect 0x0000 -> fault=0, fetch resumes.
//  T5 sequential fetch to pc 0x01FE then 0x0200 -> word at 0x01FE delivered, then fault=1.
//  T6 HALT_DETECT_EN, mem[6]=FFFF -> FFFF delivered at pc 6, halted=1, imem_pc stays 8;
//     without the macro, fetch continues to pc 8.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC into a 16-bit async-read instruction memory and
// buffers words in a prefetch FIFO for decode. `HALT_DETECT_EN enables HALT (16'hFFFF) detection.
module fetch_sequencer #(
  parameter int          MEM_BYTES  = 512,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_data,
  output logic [15:0] ins_pc,
  output logic        halted,
  output logic        fault
);
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW       = PW + 1;
  localparam logic [15:0]     LAST_PC  = 16'(MEM_BYTES - 2);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
`ifdef HALT_DETECT_EN
  localparam logic [15:0]     HALT_WORD = 16'hFFFF;
`endif

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [15:0]   fetch_pc_r, fetch_pc_nxt_s;
  logic [15:0]   data_mem_r [FIFO_DEPTH];
  logic [15:0]   pc_mem_r   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CW-1:0] count_r, left_s, count_nxt_s;
  logic          valid_r, halted_r, fault_r, halted_nxt_s;
  logic [15:0]   head_data_r, head_pc_r, head_data_nxt_s, head_pc_nxt_s;
  logic          pop_s, try_s, bad_s, push_s, halt_s;

  function automatic logic pc_bad(input logic [15:0] pc);
    return pc[0] || (pc > LAST_PC);
  endfunction

  // Next-state computation for the FSM, fetch PC, FIFO pointers and head outputs
  always_comb begin
    pop_s  = valid_r && ins_ready;
    try_s  = !redirect_valid && (state_r == FETCH) && ((count_r != FULL_CNT) || pop_s);
    bad_s  = pc_bad(fetch_pc_r);
    push_s = try_s && !bad_s;
`ifdef HALT_DETECT_EN
    halt_s = push_s && (imem_ins == HALT_WORD);
`else
    halt_s = 1'b0;
`endif
    left_s = pop_s ? (count_r - CW'(1)) : count_r;
    if (redirect_valid) begin
      // The handshake this cycle still completes; everything else is discarded.
      rd_ptr_nxt_s   = PW'(0);
      wr_ptr_nxt_s   = PW'(0);
      count_nxt_s    = CW'(0);
      fetch_pc_nxt_s = redirect_pc;
      state_nxt_s    = FETCH;
    end else begin
      rd_ptr_nxt_s   = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
      wr_ptr_nxt_s   = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
      count_nxt_s    = push_s ? (left_s + CW'(1)) : left_s;
      fetch_pc_nxt_s = push_s ? (fetch_pc_r + 16'd2) : fetch_pc_r;
      if (try_s && bad_s) begin
        state_nxt_s = FAULT;
      end else if (halt_s) begin
        state_nxt_s = HALTED;
      end else begin
        state_nxt_s = state_r;
      end
    end
    if (count_nxt_s == CW'(0)) begin
      head_data_nxt_s = 16'h0000;
      head_pc_nxt_s   = 16'h0000;
    end else if (push_s && (left_s == CW'(0))) begin
      head_data_nxt_s = imem_ins;
      head_pc_nxt_s   = fetch_pc_r;
    end else begin
      head_data_nxt_s = data_mem_r[rd_ptr_nxt_s];
      head_pc_nxt_s   = pc_mem_r[rd_ptr_nxt_s];
    end
`ifdef HALT_DETECT_EN
    halted_nxt_s = (state_nxt_s == HALTED) && (count_nxt_s == CW'(0));
`else
    halted_nxt_s = 1'b0;
`endif
  end

  // FSM, fetch PC, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FETCH;
      fetch_pc_r  <= RESET_PC;
      rd_ptr_r    <= PW'(0);
      wr_ptr_r    <= PW'(0);
      count_r     <= CW'(0);
      valid_r     <= 1'b0;
      head_data_r <= 16'h0000;
      head_pc_r   <= 16'h0000;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fetch_pc_r  <= fetch_pc_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      valid_r     <= (count_nxt_s != CW'(0));
      head_data_r <= head_data_nxt_s;
      head_pc_r   <= head_pc_nxt_s;
      halted_r    <= halted_nxt_s;
      fault_r     <= (state_nxt_s == FAULT);
    end
  end

  // Prefetch storage; entries are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= imem_ins;
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
    end
  end

  assign imem_pc   = fetch_pc_r;
  assign ins_valid = valid_r;
  assign ins_data  = head_data_r;
  assign ins_pc    = head_pc_r;
  assign halted    = halted_r;
  assign fault     = fault_r;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, HALT sequence and randomized
// traffic checked against a queue-based reference model.
module tb_fetch_sequencer;
  localparam int DEPTH = 2;
`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic [15:0] imem_pc, imem_ins, redirect_pc, ins_data, ins_pc;
  logic        redirect_valid, ins_valid, ins_ready, halted, fault;
  logic [15:0] wmem [0:32767];
  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_ins(imem_ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .halted(halted), .fault(fault)
  );

  assign imem_ins = wmem[imem_pc[15:1]];

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic rv; logic [15:0] rpc; logic rdy;
    logic ev; logic [15:0] ed; logic [15:0] ep; logic ef; logic [15:0] eim;
  } vec_t;
  vec_t vecs[$];

  typedef struct packed { logic [15:0] d; logic [15:0] p; } ent_t;
  ent_t        mq[$];
  logic [15:0] mpc;
  int          mmode;  // 0 fetching, 1 halted, 2 fault

  task automatic add(input logic rst, input logic rv, input logic [15:0] rpc, input logic rdy,
                     input logic ev, input logic [15:0] ed, input logic [15:0] ep,
                     input logic ef, input logic [15:0] eim);
    vecs.push_back('{rst, rv, rpc, rdy, ev, ed, ep, ef, eim});
  endtask

  task automatic check(input string name, input logic ev, input logic [15:0] ed,
                       input logic [15:0] ep, input logic ef, input logic eh,
                       input logic [15:0] eim);
    checks++;
    if (ins_valid !== ev || ins_data !== ed || ins_pc !== ep || fault !== ef ||
        halted !== eh || imem_pc !== eim) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%h pc=%h f=%0b h=%0b im=%h, need v=%0b d=%h pc=%h f=%0b h=%0b im=%h",
               name, ins_valid, ins_data, ins_pc, fault, halted, imem_pc, ev, ed, ep, ef, eh, eim);
    end
  endtask

  task automatic step(input logic rv, input logic [15:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    ins_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic rv, input logic [15:0] rpc, input logic rdy);
    int          sz;
    logic        pop;
    logic [15:0] w;
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    w   = wmem[mpc[15:1]];
    if (rv) begin
      mq.delete();
      mpc   = rpc;
      mmode = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mmode == 0 && (sz < DEPTH || pop)) begin
        if (mpc[0] || mpc > 16'd510) begin
          mmode = 2;
        end else begin
          mq.push_back('{w, mpc});
          if (HALT_EN && w == 16'hFFFF) mmode = 1;
          mpc = mpc + 16'd2;
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step(1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; ins_ready = 1'b0;
    for (int i = 0; i < 32768; i++) wmem[i] = 16'hA000 | 16'(i * 2);
    wmem[0] = 16'h1111; wmem[1] = 16'h2222; wmem[2] = 16'h3333; wmem[3] = 16'h4444;

    // rst rv rpc rdy | valid data pc fault imem_pc
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 16'h1111, 16'h0000, 0, 16'h0002);
    add(0, 0, 16'h0000, 1, 1, 16'h2222, 16'h0002, 0, 16'h0004);
    add(0, 0, 16'h0000, 1, 1, 16'h3333, 16'h0004, 0, 16'h0006);
    add(0, 0, 16'h0000, 1, 1, 16'h4444, 16'h0006, 0, 16'h0008);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 16'h0002);
    add(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 16'h0004);
    add(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 16'h0004);
    add(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 16'h0004);
    add(0, 0, 16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 16'h0004);
    add(0, 0, 16'h0000, 1, 1, 16'h2222, 16'h0002, 0, 16'h0006);
    add(0, 1, 16'h0020, 1, 0, 16'h0000, 16'h0000, 0, 16'h0020);
    add(0, 0, 16'h0000, 1, 1, 16'hA020, 16'h0020, 0, 16'h0022);
    add(0, 0, 16'h0000, 1, 1, 16'hA022, 16'h0022, 0, 16'h0024);
    add(0, 1, 16'h0021, 0, 0, 16'h0000, 16'h0000, 0, 16'h0021);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h0021);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 16'h0021);
    add(0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, 0, 16'h0000, 1, 1, 16'h1111, 16'h0000, 0, 16'h0002);
    add(0, 1, 16'h01FC, 1, 0, 16'h0000, 16'h0000, 0, 16'h01FC);
    add(0, 0, 16'h0000, 1, 1, 16'hA1FC, 16'h01FC, 0, 16'h01FE);
    add(0, 0, 16'h0000, 1, 1, 16'hA1FE, 16'h01FE, 0, 16'h0200);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 16'h0200);
    add(0, 1, 16'h01FC, 0, 0, 16'h0000, 16'h0000, 0, 16'h01FC);
    add(0, 0, 16'h0000, 0, 1, 16'hA1FC, 16'h01FC, 0, 16'h01FE);
    add(0, 0, 16'h0000, 0, 1, 16'hA1FC, 16'h01FC, 0, 16'h0200);
    add(0, 0, 16'h0000, 0, 1, 16'hA1FC, 16'h01FC, 0, 16'h0200);
    add(0, 0, 16'h0000, 1, 1, 16'hA1FE, 16'h01FE, 1, 16'h0200);
    add(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 16'h0200);

    #3;
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst ? 1'b0 : 1'b1;
      step(vecs[k].rv, vecs[k].rpc, vecs[k].rdy);
      check($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ed, vecs[k].ep, vecs[k].ef, 1'b0, vecs[k].eim);
    end

    // HALT word at pc 6
    wmem[3] = 16'hFFFF;
    reset_dut();
    step(1'b0, 16'h0000, 1'b1); check("halt_w0", 1, 16'h1111, 16'h0000, 0, 0, 16'h0002);
    step(1'b0, 16'h0000, 1'b1); check("halt_w1", 1, 16'h2222, 16'h0002, 0, 0, 16'h0004);
    step(1'b0, 16'h0000, 1'b1); check("halt_w2", 1, 16'h3333, 16'h0004, 0, 0, 16'h0006);
    step(1'b0, 16'h0000, 1'b1); check("halt_w3", 1, 16'hFFFF, 16'h0006, 0, 0, 16'h0008);
    step(1'b0, 16'h0000, 1'b1);
    if (HALT_EN) begin
      check("halt_set", 0, 16'h0000, 16'h0000, 0, 1, 16'h0008);
      step(1'b0, 16'h0000, 1'b1); check("halt_hold", 0, 16'h0000, 16'h0000, 0, 1, 16'h0008);
      step(1'b1, 16'h0000, 1'b1); check("halt_exit", 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    end else begin
      check("ffff_plain", 1, 16'hA008, 16'h0008, 0, 0, 16'h000A);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 256; i++)
      wmem[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
    reset_dut();
    mq.delete(); mpc = 16'h0000; mmode = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        rv, rdy, ev;
      logic [15:0] rpc;
      int          sel;
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rpc = 16'($urandom_range(0, 255)) * 16'd2 + 16'd1;
      else if (sel == 1) rpc = 16'h01F0 + 16'($urandom_range(0, 7)) * 16'd2;
      else if (sel == 2) rpc = 16'h0200 + 16'($urandom_range(0, 63)) * 16'd2;
      else               rpc = 16'($urandom_range(0, 255)) * 16'd2;
      model_step(rv, rpc, rdy);
      step(rv, rpc, rdy);
      ev = (mq.size() != 0);
      check($sformatf("rand%0d", c), ev, ev ? mq[0].d : 16'h0000, ev ? mq[0].p : 16'h0000,
            mmode == 2, HALT_EN && mmode == 1 && !ev, mpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
